// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the pipeline hazard/flush controller.
package pipe_pkg;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;
  localparam logic [1:0] TNEW_3 = 2'd3;

  localparam int unsigned MULT_CYC_DEFAULT = 5;
  localparam int unsigned DIV_CYC_DEFAULT  = 10;
  localparam int unsigned MD_CNT_W         = 4;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } exc_state_t;

  // A source operand stalls when a younger-needed value is still in flight
  // in E or M; register 0 is hardwired and never stalls.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3_e,
    input logic [1:0] tnew_e,
    input logic [4:0] a3_m,
    input logic [1:0] tnew_m
  );
    return (src != 5'd0) &&
           (((src == a3_e) && (tuse < tnew_e)) ||
            ((src == a3_m) && (tuse < tnew_m)));
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy counter: loads the op latency on issue, drains to zero.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEFAULT,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  logic [MD_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and exception-flush control for the five-stage pipeline.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEFAULT,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] a3_e,
  input  logic [4:0] a3_m,
  input  logic [1:0] tnew_e,
  input  logic [1:0] tnew_m,
  input  logic       md_start_e,
  input  logic       md_div_e,
  input  logic       md_use_d,
  input  logic       eret_d,
  input  logic       exc_m,
  output logic       stall_d,
  output logic       clr_d,
  output logic       clr_e,
  output logic       clr_m,
  output logic       exc_redirect,
  output logic       md_busy
);

  exc_state_t state, state_next;
  logic       hz_rs, hz_rt, md_stall, stall;

  // An exception squashes the issuing mult/div, so it never occupies the unit.
  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (md_start_e & ~exc_m),
    .div   (md_div_e),
    .busy  (md_busy)
  );

  assign hz_rs    = src_hazard(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
  assign hz_rt    = src_hazard(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
  assign md_stall = md_use_d & (md_busy | md_start_e);
  assign stall    = hz_rs | hz_rt | md_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = NORMAL;
    stall_d      = 1'b0;
    clr_d        = 1'b0;
    clr_e        = 1'b0;
    clr_m        = 1'b0;
    exc_redirect = 1'b0;
    if (exc_m) begin
      clr_d        = 1'b1;
      clr_e        = 1'b1;
      clr_m        = 1'b1;
      exc_redirect = 1'b1;
      state_next   = FLUSH;
    end else if (state == FLUSH) begin
      clr_d = 1'b1;
    end else if (stall) begin
      stall_d = 1'b1;
      clr_e   = 1'b1;
    end else if (eret_d) begin
      clr_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: cycle model plus directed checks.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, a3_e, a3_m;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic       md_start_e, md_div_e, md_use_d, eret_d, exc_m;
  logic       stall_d, clr_d, clr_e, clr_m, exc_redirect, md_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .tuse_rs_d    (tuse_rs_d),
    .tuse_rt_d    (tuse_rt_d),
    .a3_e         (a3_e),
    .a3_m         (a3_m),
    .tnew_e       (tnew_e),
    .tnew_m       (tnew_m),
    .md_start_e   (md_start_e),
    .md_div_e     (md_div_e),
    .md_use_d     (md_use_d),
    .eret_d       (eret_d),
    .exc_m        (exc_m),
    .stall_d      (stall_d),
    .clr_d        (clr_d),
    .clr_e        (clr_e),
    .clr_m        (clr_m),
    .exc_redirect (exc_redirect),
    .md_busy      (md_busy)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: track the absolute cycle index at which the unit frees up and the
  // cycle immediately after an exception, rather than any counter or state.
  int cyc = 0;
  int md_last = -1;
  int flush_at = -1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_last  <= -1;
      flush_at <= -1;
      cyc      <= cyc + 1;
    end else begin
      cyc <= cyc + 1;
      if (md_start_e && !exc_m) md_last <= cyc + (md_div_e ? 10 : 5);
      if (exc_m) flush_at <= cyc + 1;
    end
  end

  function automatic logic hz(input logic [4:0] r, input logic [1:0] tu);
    return (r != 0) && (((r == a3_e) && (int'(tu) < int'(tnew_e))) ||
                        ((r == a3_m) && (int'(tu) < int'(tnew_m))));
  endfunction

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic busy, flush, stl;
      logic e_st, e_d, e_e, e_m, e_r;
      busy  = (cyc <= md_last);
      flush = (flush_at == cyc);
      stl   = hz(rs_d, tuse_rs_d) || hz(rt_d, tuse_rt_d) ||
              (md_use_d && (busy || md_start_e));
      e_st = 0; e_d = 0; e_e = 0; e_m = 0; e_r = 0;
      if (exc_m) begin
        e_d = 1; e_e = 1; e_m = 1; e_r = 1;
      end else if (flush) begin
        e_d = 1;
      end else begin
        e_st = stl; e_e = stl; e_d = eret_d && !stl;
      end
      chk("m_md_busy", md_busy, busy);
      chk("m_stall_d", stall_d, e_st);
      chk("m_clr_d", clr_d, e_d);
      chk("m_clr_e", clr_e, e_e);
      chk("m_clr_m", clr_m, e_m);
      chk("m_exc_redirect", exc_redirect, e_r);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_d = 0; rt_d = 0; a3_e = 0; a3_m = 0;
    tuse_rs_d = 2'd3; tuse_rt_d = 2'd3; tnew_e = 0; tnew_m = 0;
    md_start_e = 0; md_div_e = 0; md_use_d = 0; eret_d = 0; exc_m = 0;
  endtask

  task automatic count_md_stall(input logic div, input int exp_cycles, input string name);
    int n = 0;
    bit done = 0;
    md_start_e = 1; md_div_e = div; md_use_d = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      #2;
      if (stall_d) n++;
      else done = 1;
      if (!done) begin
        step();
        md_start_e = 0;
      end
    end
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL %s: got %0d stall cycles expected %0d", name, n, exp_cycles);
    end
    md_use_d = 0;
    step();
  endtask

  initial begin
    reset = 0;
    rs_d = 0; rt_d = 0; a3_e = 0; a3_m = 0;
    tuse_rs_d = 0; tuse_rt_d = 0; tnew_e = 0; tnew_m = 0;
    md_start_e = 0; md_div_e = 0; md_use_d = 0; eret_d = 0; exc_m = 0;
    #3;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_d", stall_d, 0);
    chk("rst_clr_d", clr_d, 0);
    chk("rst_clr_m", clr_m, 0);
    chk("rst_exc_redirect", exc_redirect, 0);
    cmp_en = 1;
    #5 reset = 1;
    step();
    idle_inputs();

    // Data hazard on rs in E.
    rs_d = 5; tuse_rs_d = 0; a3_e = 5; tnew_e = 1; #2;
    chk("hz_rs_e_stall", stall_d, 1);
    chk("hz_rs_e_clr_e", clr_e, 1);
    step();
    rs_d = 0; #2;
    chk("r0_stall", stall_d, 0);
    chk("r0_clr_e", clr_e, 0);
    step();
    // rt vs M: strict compare at the boundary.
    idle_inputs(); rt_d = 7; tuse_rt_d = 1; a3_m = 7; tnew_m = 2; #2;
    chk("hz_rt_m_stall", stall_d, 1);
    step();
    tuse_rt_d = 2; #2;
    chk("hz_rt_m_equal", stall_d, 0);
    step();
    idle_inputs();

    count_md_stall(1, 11, "div_stall_cycles");
    count_md_stall(0, 6, "mult_stall_cycles");

    // Exception during pending data stall.
    rs_d = 5; tuse_rs_d = 0; a3_e = 5; tnew_e = 1; exc_m = 1; #2;
    chk("exc_clr_d", clr_d, 1);
    chk("exc_clr_e", clr_e, 1);
    chk("exc_clr_m", clr_m, 1);
    chk("exc_redirect", exc_redirect, 1);
    chk("exc_stall_d", stall_d, 0);
    step();
    exc_m = 0; #2;
    chk("flush_clr_d", clr_d, 1);
    chk("flush_stall_d", stall_d, 0);
    chk("flush_clr_e", clr_e, 0);
    chk("flush_clr_m", clr_m, 0);
    step(); #2;
    chk("post_flush_stall", stall_d, 1);
    chk("post_flush_clr_d", clr_d, 0);
    step();
    idle_inputs();

    // Exception squashes mult/div issue.
    md_start_e = 1; md_div_e = 1; exc_m = 1;
    step();
    idle_inputs(); #2;
    chk("exc_md_no_load", md_busy, 0);
    step(); step();

    // Eret.
    eret_d = 1; #2;
    chk("eret_clr_d", clr_d, 1);
    step();
    rs_d = 5; tuse_rs_d = 0; a3_e = 5; tnew_e = 1; #2;
    chk("eret_hz_clr_d", clr_d, 0);
    chk("eret_hz_stall", stall_d, 1);
    step();
    idle_inputs();

    // Async reset in FLUSH with counter at 7.
    md_start_e = 1; md_div_e = 1;
    step();                       // counter 10
    idle_inputs();
    step(); step();               // 9, 8
    exc_m = 1;
    step();                       // 7, FLUSH
    exc_m = 0; #1;
    chk("pre_rst_busy", md_busy, 1);
    chk("pre_rst_flush", clr_d, 1);
    reset = 0; #1;
    chk("async_rst_busy", md_busy, 0);
    chk("async_rst_clr_d", clr_d, 0);
    step();
    reset = 1;
    step(); step();
    chk("after_rst_busy", md_busy, 0);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach end, expected completion");
    $fatal(1, "timeout");
  end

endmodule
